// File: rtl/median_result_writer.sv
// Write-back stage of the median filter: streams interior pixels to frame memory.
// Define MEDIAN_WRITER_BORDER_FILL_EN to pre-fill the one-pixel border ring with BORDER_VAL.
module median_result_writer #(
  parameter int          IMG_W      = 64,
  parameter int          IMG_H      = 64,
  parameter int          DATA_W     = 8,
  parameter int          ADDR_W     = 12,
  parameter int unsigned BORDER_VAL = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 3);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 3);

`ifdef MEDIAN_WRITER_BORDER_FILL_EN
  typedef enum logic [1:0] {IDLE, BORDER, STREAM, DONE} state_t;
  typedef enum logic [1:0] {B_TOP, B_BOTTOM, B_SIDES} bphase_t;

  localparam logic [ADDR_W-1:0] TOP_END   = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] BOT_START = ADDR_W'((IMG_H - 1) * IMG_W);
  localparam logic [ADDR_W-1:0] BOT_END   = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] SIDE_END  = ADDR_W'((IMG_H - 1) * IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] SIDE_STEP = ADDR_W'(IMG_W - 1);

  bphase_t bphase;
  logic    right_side;
`else
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
`endif

  state_t            state;
  logic [CNT_W-1:0]  col;
  logic [CNT_W-1:0]  row;
  logic [ADDR_W-1:0] int_addr;

  // Interior (row, col) maps to the full image shifted by one pixel in each direction.
  assign int_addr = (ADDR_W'(row) + ADDR_W'(1)) * ADDR_W'(IMG_W) + ADDR_W'(col) + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef MEDIAN_WRITER_BORDER_FILL_EN
      bphase     <= B_TOP;
      right_side <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          wr_en    <= 1'b0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          if (start) begin
            col     <= '0;
            row     <= '0;
            busy    <= 1'b1;
            wr_data <= DATA_W'(BORDER_VAL);
`ifdef MEDIAN_WRITER_BORDER_FILL_EN
            state      <= BORDER;
            wr_en      <= 1'b1;
            wr_addr    <= '0;
            bphase     <= B_TOP;
            right_side <= 1'b0;
`else
            state    <= STREAM;
            in_ready <= 1'b1;
`endif
          end
        end

`ifdef MEDIAN_WRITER_BORDER_FILL_EN
        // Walk the ring by address: top row, bottom row, then left/right pairs per row.
        BORDER: begin
          case (bphase)
            B_TOP: begin
              if (wr_addr == TOP_END) begin
                wr_addr <= BOT_START;
                bphase  <= B_BOTTOM;
              end else begin
                wr_addr <= wr_addr + ADDR_W'(1);
              end
            end
            B_BOTTOM: begin
              if (wr_addr == BOT_END) begin
                wr_addr    <= ROW_STEP;
                bphase     <= B_SIDES;
                right_side <= 1'b0;
              end else begin
                wr_addr <= wr_addr + ADDR_W'(1);
              end
            end
            default: begin
              if (!right_side) begin
                wr_addr    <= wr_addr + SIDE_STEP;
                right_side <= 1'b1;
              end else if (wr_addr == SIDE_END) begin
                wr_en    <= 1'b0;
                in_ready <= 1'b1;
                state    <= STREAM;
              end else begin
                wr_addr    <= wr_addr + ADDR_W'(1);
                right_side <= 1'b0;
              end
            end
          endcase
        end
`endif

        STREAM: begin
          // in_ready only drops after the final accept, while its write is on the bus.
          if (!in_ready) begin
            state      <= DONE;
            wr_en      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else if (in_valid) begin
            wr_en   <= 1'b1;
            wr_data <= in_data;
            wr_addr <= int_addr;
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                in_ready <= 1'b0;
              end else begin
                row <= row + CNT_W'(1);
              end
            end else begin
              col <= col + CNT_W'(1);
            end
          end else begin
            wr_en <= 1'b0;
          end
        end

        DONE: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
          wr_en    <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_result_writer.sv
// Bench for median_result_writer: reset/idle vector table, then whole-frame runs
// checked against an address/data list generated from the raster rules.
module tb_median_result_writer;

  localparam int W         = 64;
  localparam int H         = 64;
  localparam int IW        = W - 2;
  localparam int NPIX      = (W - 2) * (H - 2);
  localparam int LAST_ADDR = (H - 2) * W + (W - 2);
  localparam int BUDGET    = 20000;
`ifdef MEDIAN_WRITER_BORDER_FILL_EN
  localparam int       NB        = 2 * W + 2 * (H - 2);
  localparam bit       BORDER_ON = 1'b1;
  localparam int       FIRST_WR  = 0;
`else
  localparam int       NB        = 0;
  localparam bit       BORDER_ON = 1'b0;
  localparam int       FIRST_WR  = W + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        frame_done;

  median_result_writer #(
    .IMG_W(W), .IMG_H(H), .DATA_W(8), .ADDR_W(12), .BORDER_VAL(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, valid;
    logic        exp_en, exp_busy, exp_ready, exp_done;
    logic [11:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  int   total = 0;
  int   bad = 0;
  vec_t vecs[10];
  wr_t  got_q[$];
  logic [7:0] acc_q[$];

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    start    = v.start;
    in_valid = v.valid;
    in_data  = 8'hA5;
  endtask

  function automatic vec_t mk(input logic r, s, v, en, bz, rdy, dn, input int addr);
    vec_t t;
    t.rst = r; t.start = s; t.valid = v;
    t.exp_en = en; t.exp_busy = bz; t.exp_ready = rdy; t.exp_done = dn;
    t.exp_addr = 12'(addr);
    return t;
  endfunction

  // Reference write order: border ring (if built in), then interior pixels in raster order.
  function automatic int exp_addr(input int k);
    int j;
    if (k < NB) begin
      if (k < W) return k;
      if (k < 2 * W) return (H - 1) * W + (k - W);
      j = k - 2 * W;
      return (1 + j / 2) * W + (j % 2) * (W - 1);
    end
    j = k - NB;
    return (j / IW + 1) * W + (j % IW) + 1;
  endfunction

  task automatic run_frame(input string tag, input int valid_pct, input int abort_at,
                           input int start_at);
    int n_acc = 0, lat_err = 0, rdy_err = 0, done_cnt = 0, done_err = 0;
    int idle_err = 0, cyc = 0, mism = 0, first_bad = -1;
    logic pend = 1'b0, prev_en = 1'b0, finished = 1'b0, start_sent = 1'b0;
    logic [7:0]  pend_d = 8'h00;
    logic [11:0] prev_addr = 12'h000;
    got_q.delete();
    acc_q.delete();
    rst = 1'b0; in_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < BUDGET) begin
      if (wr_en) begin
        got_q.push_back('{wr_addr, wr_data});
        if (!busy) rdy_err++;
      end
      if (pend && !(wr_en && wr_data == pend_d)) lat_err++;
      if (in_ready && got_q.size() < NB) rdy_err++;
      if (frame_done) begin
        done_cnt++;
        if (busy || !prev_en || prev_addr != 12'(LAST_ADDR)) done_err++;
        finished = 1'b1;
      end
      prev_en = wr_en;
      prev_addr = wr_addr;
      if (abort_at > 0 && n_acc == abort_at) begin
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".wr_en"}, wr_en, 0);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".in_ready"}, in_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (wr_en || busy || in_ready || frame_done) idle_err++;
        end
        checkOutput({tag, ".quiet_after_rst"}, idle_err, 0);
        return;
      end
      start = (start_at > 0 && n_acc == start_at && !start_sent);
      if (start) start_sent = 1'b1;
      in_valid = ($urandom_range(99) < valid_pct);
      in_data = 8'($urandom);
      pend = in_valid && in_ready;
      pend_d = in_data;
      if (pend) begin
        acc_q.push_back(in_data);
        n_acc++;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      @(negedge clk);
      if (wr_en || busy || in_ready || frame_done) idle_err++;
    end
    in_valid = 1'b0;
    checkOutput({tag, ".frame_done_seen"}, finished, 1);
    checkOutput({tag, ".frame_done_count"}, done_cnt, 1);
    checkOutput({tag, ".frame_done_timing"}, done_err, 0);
    checkOutput({tag, ".latency_errors"}, lat_err, 0);
    checkOutput({tag, ".ready_busy_errors"}, rdy_err, 0);
    checkOutput({tag, ".idle_after_done"}, idle_err, 0);
    checkOutput({tag, ".accepts"}, n_acc, NPIX);
    checkOutput({tag, ".writes"}, got_q.size(), NB + NPIX);
    if (got_q.size() == NB + NPIX && n_acc == NPIX) begin
      for (int k = 0; k < NB + NPIX; k++) begin
        int ed;
        ed = (k < NB) ? 0 : int'(acc_q[k - NB]);
        if (int'(got_q[k].addr) != exp_addr(k) || int'(got_q[k].data) != ed) begin
          mism++;
          if (first_bad < 0) first_bad = k;
        end
      end
      checkOutput({tag, ".write_list_mismatches"}, mism, 0);
      if (first_bad >= 0) begin
        checkOutput($sformatf("%s.addr[%0d]", tag, first_bad), got_q[first_bad].addr,
                    exp_addr(first_bad));
      end
    end
  endtask

  initial begin
    vecs[0] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    vecs[2] = mk(1, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk(1, 1, 1, 0, 0, 0, 0, 0);
    vecs[4] = mk(0, 0, 1, 0, 0, 0, 0, 0);
    vecs[5] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6] = mk(0, 1, 0, BORDER_ON, 1, !BORDER_ON, 0, 0);
    vecs[7] = mk(0, 0, 0, BORDER_ON, 1, !BORDER_ON, 0, BORDER_ON ? 1 : 0);
    vecs[8] = mk(1, 1, 0, 0, 0, 0, 0, 0);
    vecs[9] = mk(0, 0, 1, 0, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.wr_en", i), wr_en, vecs[i].exp_en);
      checkOutput($sformatf("vec%0d.busy", i), busy, vecs[i].exp_busy);
      checkOutput($sformatf("vec%0d.in_ready", i), in_ready, vecs[i].exp_ready);
      checkOutput($sformatf("vec%0d.frame_done", i), frame_done, vecs[i].exp_done);
      checkOutput($sformatf("vec%0d.wr_addr", i), wr_addr, vecs[i].exp_addr);
    end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] full frame, in_valid held high");
    run_frame("full", 100, 0, 0);
    if (got_q.size() == NB + NPIX) begin
      checkOutput("full.first_interior", got_q[NB].addr, W + 1);
      checkOutput("full.interior_62", got_q[NB + 61].addr, 2 * W - 2);
      checkOutput("full.interior_63", got_q[NB + 62].addr, 2 * W + 1);
      checkOutput("full.last_interior", got_q[NB + NPIX - 1].addr, LAST_ADDR);
`ifdef MEDIAN_WRITER_BORDER_FILL_EN
      checkOutput("full.border_0", got_q[0].addr, 0);
      checkOutput("full.border_64", got_q[64].addr, (H - 1) * W);
      checkOutput("full.border_128", got_q[128].addr, W);
      checkOutput("full.border_129", got_q[129].addr, 2 * W - 1);
      checkOutput("full.border_130", got_q[130].addr, 2 * W);
`endif
    end

    $display("[TB] random in_valid gaps");
    run_frame("gaps", 50, 0, 0);

    $display("[TB] reset after 1000 accepts, then restart");
    run_frame("abort", 70, 1000, 0);
    run_frame("restart", 100, 0, 0);
    if (got_q.size() > 0) checkOutput("restart.first_addr", got_q[0].addr, FIRST_WR);

    $display("[TB] start pulse while streaming");
    run_frame("start_busy", 60, 0, 500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
